// File: rtl/block_match_pkg.sv
// block_match_pkg: shared state encoding and coordinate widths for the block-match scheduler
package block_match_pkg;
  localparam int Y_W = 10;
  localparam int WORD_W = 9;
  localparam int MAX_DISP_DEF = 4;
  localparam int DISP_W = $clog2(MAX_DISP_DEF + 1);
  typedef enum logic [2:0] {IDLE, FETCH, MATCH, UPDATE, EMIT, DONE} state_t;
endpackage

// File: rtl/bm_scan_counter.sv
// bm_scan_counter: nested y/word/disparity counters with wrap and last-position flags
// Ports:
//   clk_in, rst_n_in      clock, async active-low reset
//   clear_in              restart the scan at y=0, word=0, d=0
//   d_inc_in              step to the next candidate disparity
//   blk_inc_in            step to the next block (word, wrapping into the next block row), d back to 0
//   y_out, word_out       current block top row and block word
//   d_out                 current candidate disparity
//   d_last_out            d has reached min(MAX_DISP_WORDS, word)
//   blk_last_out          current block is the final block of the frame
module bm_scan_counter
  import block_match_pkg::*;
#(
  parameter int IMG_ROWS = 240,
  parameter int WORDS_PER_ROW = 40,
  parameter int BLOCK_ROWS = 6,
  parameter int MAX_DISP_WORDS = 4,
  parameter int DW = $clog2(MAX_DISP_WORDS + 1)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clear_in,
  input  logic              d_inc_in,
  input  logic              blk_inc_in,
  output logic [Y_W-1:0]    y_out,
  output logic [WORD_W-1:0] word_out,
  output logic [DW-1:0]     d_out,
  output logic              d_last_out,
  output logic              blk_last_out
);
  // The buffer unit also reads word+1, so the last block word is one short of the row end.
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_ROW - 2);
  // Highest top row whose whole block still fits inside the image.
  localparam logic [Y_W-1:0] Y_LAST = Y_W'((IMG_ROWS / BLOCK_ROWS - 1) * BLOCK_ROWS);
  logic [DW-1:0] d_max;
  logic word_last;
  // Disparity is capped by the block word so the right candidate never goes below word 0.
  assign d_max = (word_out < WORD_W'(MAX_DISP_WORDS)) ? word_out[DW-1:0] : DW'(MAX_DISP_WORDS);
  assign d_last_out = d_out == d_max;
  assign word_last = word_out == WORD_LAST;
  assign blk_last_out = word_last && y_out == Y_LAST;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_out <= '0;
      word_out <= '0;
      d_out <= '0;
    end else if (clear_in) begin
      y_out <= '0;
      word_out <= '0;
      d_out <= '0;
    end else if (blk_inc_in) begin
      d_out <= '0;
      word_out <= word_last ? '0 : word_out + WORD_W'(1);
      y_out <= word_last ? y_out + Y_W'(BLOCK_ROWS) : y_out;
    end else if (d_inc_in) begin
      d_out <= d_out + DW'(1);
    end
  end
endmodule

// File: rtl/block_match_scheduler.sv
// block_match_scheduler: sequences buffer fetch and cost scoring per candidate disparity and emits the best disparity per block
// Ports:
//   clk_in, rst_n_in                  clock, async active-low reset (release synchronised internally)
//   start_in                          frame start pulse, honoured only when idle
//   fetch_valid_out, fetch_done_in    buffer-update command pulse and its completion
//   left_current_y, right_current_y   block top row (identical for both images)
//   left_word_idx, right_word_idx     left block word and right candidate word (left - d)
//   match_valid_out, match_done_in    cost-unit command pulse and its completion
//   match_cost_in                     candidate cost, sampled with match_done_in
//   result_valid_out, result_ready_in best-disparity result handshake
//   result_disp_out, result_cost_out  best disparity (words) and its cost
//   result_y_out, result_word_out     block position of the result
//   busy_out                          high whenever not idle
//   frame_done_out                    one-cycle pulse after the last result is accepted
module block_match_scheduler
  import block_match_pkg::*;
#(
  parameter int IMG_ROWS = 240,
  parameter int WORDS_PER_ROW = 40,
  parameter int BLOCK_ROWS = 6,
  parameter int MAX_DISP_WORDS = 4,
  parameter int COST_W = 16
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                start_in,
  output logic                                fetch_valid_out,
  output logic [Y_W-1:0]                      left_current_y,
  output logic [Y_W-1:0]                      right_current_y,
  output logic [WORD_W-1:0]                   left_word_idx,
  output logic [WORD_W-1:0]                   right_word_idx,
  input  logic                                fetch_done_in,
  output logic                                match_valid_out,
  input  logic                                match_done_in,
  input  logic [COST_W-1:0]                   match_cost_in,
  output logic                                result_valid_out,
  input  logic                                result_ready_in,
  output logic [$clog2(MAX_DISP_WORDS+1)-1:0] result_disp_out,
  output logic [COST_W-1:0]                   result_cost_out,
  output logic [Y_W-1:0]                      result_y_out,
  output logic [WORD_W-1:0]                   result_word_out,
  output logic                                busy_out,
  output logic                                frame_done_out
);
  localparam int DW = $clog2(MAX_DISP_WORDS + 1);
  state_t state;
  logic [1:0] rst_sync;
  logic rst_n;
  logic [DW-1:0] d, best_d, nb_d;
  logic [COST_W-1:0] cost_r, best_cost, nb_cost;
  logic d_last, blk_last, better, xfer;
  // Reset asserts immediately but releases two clocks later, away from the external edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];
  bm_scan_counter #(
    .IMG_ROWS(IMG_ROWS),
    .WORDS_PER_ROW(WORDS_PER_ROW),
    .BLOCK_ROWS(BLOCK_ROWS),
    .MAX_DISP_WORDS(MAX_DISP_WORDS),
    .DW(DW)
  ) u_scan (
    .clk_in(clk_in),
    .rst_n_in(rst_n),
    .clear_in(state == IDLE && start_in),
    .d_inc_in(state == UPDATE && !d_last),
    .blk_inc_in(xfer && !blk_last),
    .y_out(left_current_y),
    .word_out(left_word_idx),
    .d_out(d),
    .d_last_out(d_last),
    .blk_last_out(blk_last)
  );
  assign right_current_y = left_current_y;
  assign right_word_idx = left_word_idx - WORD_W'(d);
  assign busy_out = state != IDLE;
  assign xfer = result_valid_out && result_ready_in;
  // Strict less-than: a tie keeps the earlier, smaller disparity.
  assign better = cost_r < best_cost;
  assign nb_cost = better ? cost_r : best_cost;
  assign nb_d = better ? d : best_d;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_valid_out <= 1'b0;
      match_valid_out <= 1'b0;
      result_valid_out <= 1'b0;
      result_disp_out <= '0;
      result_cost_out <= '0;
      result_y_out <= '0;
      result_word_out <= '0;
      frame_done_out <= 1'b0;
      cost_r <= '0;
      best_cost <= '1;
      best_d <= '0;
    end else begin
      fetch_valid_out <= 1'b0;
      match_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          state <= FETCH;
          fetch_valid_out <= 1'b1;
          best_cost <= '1;
          best_d <= '0;
        end
        FETCH: if (fetch_done_in) begin
          state <= MATCH;
          match_valid_out <= 1'b1;
        end
        MATCH: if (match_done_in) begin
          state <= UPDATE;
          cost_r <= match_cost_in;
        end
        UPDATE: begin
          best_cost <= nb_cost;
          best_d <= nb_d;
          if (!d_last) begin
            state <= FETCH;
            fetch_valid_out <= 1'b1;
          end else begin
            state <= EMIT;
            result_valid_out <= 1'b1;
            result_disp_out <= nb_d;
            result_cost_out <= nb_cost;
            result_y_out <= left_current_y;
            result_word_out <= left_word_idx;
          end
        end
        EMIT: if (result_ready_in) begin
          result_valid_out <= 1'b0;
          best_cost <= '1;
          best_d <= '0;
          if (blk_last) begin
            state <= DONE;
            frame_done_out <= 1'b1;
          end else begin
            state <= FETCH;
            fetch_valid_out <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_match_scheduler.sv
// tb_block_match_scheduler: randomized directed bench scoring every block against a scan-order reference model
module tb_block_match_scheduler;
  localparam int ROWS = 12, WPR = 6, BR = 6, MAXD = 4, CW = 16;
  logic clk_in = 0, rst_n_in = 1, start_in = 0, fetch_done_in = 0, match_done_in = 0, result_ready_in = 0;
  logic [CW-1:0] match_cost_in = '0;
  logic fetch_valid_out, match_valid_out, result_valid_out, busy_out, frame_done_out;
  logic [9:0] left_current_y, right_current_y, result_y_out;
  logic [8:0] left_word_idx, right_word_idx, result_word_out;
  logic [2:0] result_disp_out;
  logic [CW-1:0] result_cost_out;
  int checks = 0, passed = 0;
  always #5 clk_in = ~clk_in;
  block_match_scheduler #(
    .IMG_ROWS(ROWS), .WORDS_PER_ROW(WPR), .BLOCK_ROWS(BR), .MAX_DISP_WORDS(MAXD), .COST_W(CW)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .fetch_valid_out(fetch_valid_out), .left_current_y(left_current_y), .right_current_y(right_current_y),
    .left_word_idx(left_word_idx), .right_word_idx(right_word_idx), .fetch_done_in(fetch_done_in),
    .match_valid_out(match_valid_out), .match_done_in(match_done_in), .match_cost_in(match_cost_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_disp_out(result_disp_out), .result_cost_out(result_cost_out),
    .result_y_out(result_y_out), .result_word_out(result_word_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({fetch_valid_out, match_valid_out, result_valid_out, busy_out, frame_done_out}), 0);
    chk({tag, "_y"}, 32'({left_current_y, right_current_y}), 0);
    chk({tag, "_words"}, 32'({left_word_idx, right_word_idx}), 0);
    chk({tag, "_res"}, 32'({result_disp_out, result_cost_out}), 0);
    chk({tag, "_pos"}, 32'({result_y_out, result_word_out}), 0);
  endtask
  function automatic logic sig(input int which);
    return which == 0 ? fetch_valid_out : which == 1 ? match_valid_out : result_valid_out;
  endfunction
  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (sig(which) !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, 32'(sig(which)), 1);
  endtask
  task automatic pulse_start();
    start_in = 1;
    @(negedge clk_in);
    start_in = 0;
  endtask
  // mode 0 random costs/latencies/stalls with stray done pulses, 1 all costs 5, 2 cost 10-d, 3 costs near all-ones
  task automatic serve_frame(input int mode, input int long_blk, input int start_blk);
    int blk = 0;
    for (int y = 0; y + BR <= ROWS; y += BR)
      for (int w = 0; w <= WPR - 2; w++) begin
        int dmax, best, bd, stall, lat, c;
        logic s;
        dmax = w < MAXD ? w : MAXD;
        best = 'hFFFF;
        bd = 0;
        for (int d = 0; d <= dmax; d++) begin
          wait_sig(0, "fetch_cmd");
          chk("fetch_y", 32'(left_current_y), y);
          chk("fetch_ry", 32'(right_current_y), y);
          chk("fetch_lw", 32'(left_word_idx), w);
          chk("fetch_rw", 32'(right_word_idx), w - d);
          lat = $urandom_range(1, 3);
          if (blk == start_blk && d == 0) start_in = 1;
          for (int i = 0; i < lat; i++) begin
            @(negedge clk_in);
            start_in = 0;
            match_done_in = (mode == 0 && i == 0 && lat > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == 0) chk("fetch_pulse", 32'(fetch_valid_out), 0);
          end
          chk("fetch_hold_rw", 32'(right_word_idx), w - d);
          fetch_done_in = 1;
          @(negedge clk_in);
          fetch_done_in = 0;
          wait_sig(1, "match_cmd");
          c = mode == 1 ? 5 : mode == 2 ? 10 - d : mode == 3 ? ($urandom_range(0, 1) ? 'hFFFF : 'hFFFE) : $urandom_range(0, 20);
          lat = $urandom_range(1, 3);
          for (int i = 0; i < lat; i++) begin
            @(negedge clk_in);
            fetch_done_in = (mode == 0 && i == 0 && lat > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == 0) chk("match_pulse", 32'(match_valid_out), 0);
          end
          match_cost_in = CW'(c);
          match_done_in = 1;
          @(negedge clk_in);
          match_done_in = 0;
          match_cost_in = CW'($urandom);
          if (c < best) begin
            best = c;
            bd = d;
          end
        end
        stall = blk == long_blk ? 10 : mode == 0 ? $urandom_range(0, 2) : 0;
        if (stall == 0) result_ready_in = 1;
        wait_sig(2, "result_valid");
        chk("result_disp", 32'(result_disp_out), bd);
        chk("result_cost", 32'(result_cost_out), best);
        chk("result_y", 32'(result_y_out), y);
        chk("result_word", 32'(result_word_out), w);
        for (int i = 0; i < stall; i++) begin
          @(negedge clk_in);
          chk("stall_valid", 32'(result_valid_out), 1);
          chk("stall_disp", 32'(result_disp_out), bd);
          chk("stall_cost", 32'(result_cost_out), best);
          chk("stall_pos", 32'({result_y_out, result_word_out}), 32'({10'(y), 9'(w)}));
          chk("stall_nofetch", 32'(fetch_valid_out), 0);
        end
        result_ready_in = 1;
        @(negedge clk_in);
        result_ready_in = 0;
        chk("result_drop", 32'(result_valid_out), 0);
        if (y + 2 * BR > ROWS && w == WPR - 2) begin
          chk("frame_done", 32'(frame_done_out), 1);
          @(negedge clk_in);
          chk("frame_done_pulse", 32'(frame_done_out), 0);
          chk("idle_busy", 32'(busy_out), 0);
        end else begin
          chk("busy", 32'(busy_out), 1);
          chk("no_early_done", 32'(frame_done_out), 0);
          if (blk == long_blk) begin
            s = fetch_valid_out;
            if (!s) begin
              @(negedge clk_in);
              s = fetch_valid_out;
            end
            chk("release_fetch", 32'(s), 1);
          end
        end
        blk++;
      end
  endtask
  initial begin
    #1 rst_n_in = 0;
    @(negedge clk_in);
    check_zero("reset");
    repeat (2) @(negedge clk_in);
    check_zero("reset_hold");
    rst_n_in = 1;
    repeat (4) @(negedge clk_in);
    chk("idle_after_reset", 32'(busy_out), 0);
    pulse_start();
    serve_frame(2, -1, -1);
    pulse_start();
    serve_frame(1, 3, 2);
    pulse_start();
    serve_frame(3, -1, -1);
    pulse_start();
    serve_frame(0, -1, 4);
    pulse_start();
    serve_frame(0, 7, -1);
    pulse_start();
    wait_sig(0, "mr_fetch0");
    @(negedge clk_in);
    fetch_done_in = 1;
    @(negedge clk_in);
    fetch_done_in = 0;
    wait_sig(1, "mr_match0");
    @(negedge clk_in);
    match_cost_in = 16'd9;
    match_done_in = 1;
    @(negedge clk_in);
    match_done_in = 0;
    result_ready_in = 1;
    wait_sig(2, "mr_result");
    chk("mr_cost", 32'(result_cost_out), 9);
    @(negedge clk_in);
    result_ready_in = 0;
    wait_sig(0, "mr_fetch1");
    chk("mr_word", 32'(left_word_idx), 1);
    @(negedge clk_in);
    fetch_done_in = 1;
    @(negedge clk_in);
    fetch_done_in = 0;
    wait_sig(1, "mr_match1");
    @(negedge clk_in);
    rst_n_in = 0;
    #1 check_zero("mid_reset");
    repeat (5) begin
      @(negedge clk_in);
      chk("mr_no_valid", 32'(result_valid_out), 0);
      chk("mr_no_done", 32'(frame_done_out), 0);
      chk("mr_busy", 32'(busy_out), 0);
    end
    rst_n_in = 1;
    repeat (4) @(negedge clk_in);
    chk("mr_idle", 32'(busy_out), 0);
    pulse_start();
    serve_frame(0, -1, -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/block_match_scheduler.md
Name: block_match_scheduler

Overview:
- Sequences the stereo block-matching datapath over one frame.
- For every left block position it sweeps candidate right positions by word disparity. For each candidate it commands the buffer-update unit to fill the left/right front/back buffers, then commands the cost unit to score them.
- Tracks the minimum-cost disparity per block and emits one result per block through a ready/valid handshake.
- Sits between the frame-level control (start/done) and the buffer-update and cost engines.

Parameters:
- IMG_ROWS, 240: image rows scanned.
- WORDS_PER_ROW, 40: 48-bit words per row. Memory address stride.
- BLOCK_ROWS, 6: rows per block. Also the row step between block rows.
- MAX_DISP_WORDS, 4: largest disparity searched, in words.
- COST_W, 16: width of the match cost.

Ports:
- clk_in, input, 1: clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- start_in, input, 1: single-cycle frame start. Ignored unless in IDLE.
- fetch_valid_out, output, 1: one-cycle command to the buffer-update unit.
- left_current_y, output, 10: left block top row.
- right_current_y, output, 10: right block top row. Always equal to left_current_y.
- left_word_idx, output, 9: left block word.
- right_word_idx, output, 9: right candidate word.
- fetch_done_in, input, 1: buffer-update unit finished (its valid_out).
- match_valid_out, output, 1: one-cycle command to the cost unit.
- match_done_in, input, 1: cost unit result valid.
- match_cost_in, input, COST_W: cost for the current candidate. Sampled when match_done_in=1.
- result_valid_out, output, 1: best-disparity result available.
- result_ready_in, input, 1: consumer accepts the result.
- result_disp_out, output, 3: best disparity in words, width $clog2(MAX_DISP_WORDS+1).
- result_cost_out, output, COST_W: best cost.
- result_y_out, output, 10: block row of the result.
- result_word_out, output, 9: block word of the result.
- busy_out, output, 1: high in every state except IDLE.
- frame_done_out, output, 1: one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - State is IDLE.
  - All outputs are 0. This includes y, word, disparity and cost registers.
  - The internal best cost is set to all-ones.
- Scan order:
  - left_current_y runs 0, BLOCK_ROWS, 2*BLOCK_ROWS, … while y+BLOCK_ROWS <= IMG_ROWS. Default: 0..234, i.e. 40 block rows.
  - Within a row, left_word_idx runs 0..WORDS_PER_ROW-2, because the buffer unit also reads word_idx+1.
  - For each block, d runs 0..min(MAX_DISP_WORDS, left_word_idx), and right_word_idx = left_word_idx - d. Right words never go negative.
- States:
  - IDLE: on start_in, clear y, word, d and best; go to FETCH.
  - FETCH: in the first cycle of entry, fetch_valid_out=1 for exactly one cycle. Coordinate outputs are stable from that cycle until fetch_done_in. Wait for fetch_done_in, then go to MATCH.
  - MATCH: match_valid_out=1 for one cycle on entry. Wait for match_done_in, then register the cost and go to UPDATE.
  - UPDATE (1 cycle):
    - If cost < best, set best = cost and best_d = d. Strict less-than, so a tie keeps the smaller d.
    - If d < d_max: d+1, go to FETCH.
    - Otherwise go to EMIT.
  - EMIT: result_* registered and result_valid_out=1, held until result_ready_in. The transfer completes in the cycle where both are high.
  - After the transfer:
    - If more blocks remain: advance word, or wrap word to 0 and y += BLOCK_ROWS. Reset d=0 and best=all-ones. Go to FETCH.
    - On the last block, go to DONE.
  - DONE: frame_done_out=1 for one cycle, then IDLE.
- Handshake rules:
  - fetch_done_in or match_done_in arriving outside its wait state is ignored.
  - A done input may arrive in the cycle right after the command. Minimum per-candidate overhead is 4 cycles (FETCH cmd, done, MATCH cmd, done) plus 1 cycle of UPDATE.
  - result_ready_in may already be high on entry to EMIT, giving zero-stall transfer.
  - The start_in pulse is ignored while busy.
- Arithmetic:
  - Coordinate counters are unsigned.
  - d_max is computed combinationally as min(MAX_DISP_WORDS, left_word_idx).
- Reset mid-frame: aborts immediately. No partial result is emitted and no frame_done pulse occurs.

Decomposition:
- Package block_match_pkg holds:
  - the state enum (IDLE, FETCH, MATCH, UPDATE, EMIT, DONE);
  - localparams for coordinate widths (10 for y, 9 for word) and the disparity width.
- Natural sub-module: bm_scan_counter. It holds the y/word/d nested counters with their wrap and last-flags, and leaves the FSM to the top.

Test Plan:
- Reset during MATCH → all outputs 0 the same cycle, busy_out=0, no result_valid_out, no frame_done_out.
- start_in, done inputs returned 1 cycle after each command, cost = 10-d for word 3 → candidates right words 3,2,1,0. Result disp=3, cost=7, y=0, word=3.
- Equal costs (5) for all candidates → result_disp_out=0 (tie keeps smallest d).
- Word 0 block → exactly one fetch/match pair (d_max=0) and right_word_idx=0. Word 38 → last word, then wrap to word 0, y=6.
- result_ready_in held low 10 cycles → result_valid_out and all result_* stable, no new fetch_valid_out issued. Release → next fetch_valid_out within 2 cycles.
- Full frame with IMG_ROWS=12, WORDS_PER_ROW=4 → 6 results in scan order, then one frame_done_out pulse, busy_out low. A start_in pulse during busy → ignored.
